// File: rtl/degamma_pkg.sv
// Shared types and sizing for the degamma LUT configuration controller.
// Default widths match the 8-bit in / 12-bit out LUT datapath.
package degamma_pkg;

    localparam int DG_IN_DW  = 8;
    localparam int DG_OUT_DW = 12;
    localparam int LUT_DEPTH = 1 << DG_IN_DW;

    typedef logic [DG_OUT_DW-1:0] entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

endpackage

// File: rtl/level_to_pulse.sv
// Rising-edge detector: one-cycle pulse when level goes 0 -> 1.
// Registered previous level resets low.
module level_to_pulse (
    input  logic clk,
    input  logic rstn,
    input  logic level_in,
    output logic pulse_out
);

    logic level_q;
    logic level_d;

    always_comb level_d = level_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) level_q <= 1'b0;
        else       level_q <= level_d;
    end

    assign pulse_out = level_in & ~level_q;

endmodule

// File: rtl/degamma_lut_ctrl.sv
// Frame-synchronous degamma LUT bank controller: host writes the back bank,
// commit swaps banks at vsync, then front is copied into back.
module degamma_lut_ctrl
    import degamma_pkg::*;
#(
    parameter int IN_DW  = DG_IN_DW,
    parameter int OUT_DW = DG_OUT_DW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vsync_in,
    input  logic              reg_degamma_en,
    input  logic              cfg_wr,
    input  logic [IN_DW-1:0]  cfg_addr,
    input  logic [OUT_DW-1:0] cfg_wdata,
    input  logic              cfg_commit,
    output logic              cfg_ready,
    output logic              commit_pending,
    output logic              swap_done,
    output logic              degamma_en_active,
    output logic              bank_sel,
    output logic              lut_we,
    output logic              lut_wbank,
    output logic [IN_DW-1:0]  lut_waddr,
    output logic [OUT_DW-1:0] lut_wdata,
    output logic              lut_rd_en,
    output logic              lut_rbank,
    output logic [IN_DW-1:0]  lut_raddr,
    input  logic [OUT_DW-1:0] lut_rdata
);

    localparam int DEPTH = 1 << IN_DW;
    localparam logic [IN_DW:0] LAST_RD = (IN_DW+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [IN_DW:0]    cnt_q, cnt_d;
    logic              bank_q, bank_d;
    logic              pend_q, pend_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              rd_q, rd_d;
    logic              we_q, we_d;
    logic              cp_q, cp_d;
    logic [IN_DW-1:0]  waddr_q, waddr_d;
    logic [OUT_DW-1:0] wdata_q, wdata_d;
    logic              vsync_rise;
    logic              host_wr;

    level_to_pulse u_vsync_edge (
        .clk       (clk),
        .rstn      (rstn),
        .level_in  (vsync_in),
        .pulse_out (vsync_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        en_d    = vsync_rise ? reg_degamma_en : en_q;
        host_wr = cfg_wr & rdy_q;
        // Copy write-back trails its read by one cycle
        we_d    = host_wr | rd_q;
        cp_d    = rd_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (rd_q) begin
            waddr_d = cnt_q[IN_DW-1:0];
        end else if (host_wr) begin
            waddr_d = cfg_addr;
            wdata_d = cfg_wdata;
        end
        unique case (state_q)
            IDLE: begin
                if (vsync_rise & pend_q) begin
                    state_d = COPY;
                    bank_d  = ~bank_q;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                end else if (cfg_commit & rdy_q) begin
                    pend_d = 1'b1;
                end
            end
            COPY: begin
                cnt_d = cnt_q + 1'b1;
                rd_d  = cnt_q < LAST_RD;
                // MSB set: last write-back is in flight this cycle
                if (cnt_q[IN_DW]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE) & ~pend_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            cp_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            cp_q    <= cp_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign cfg_ready         = rdy_q;
    assign commit_pending    = pend_q;
    assign swap_done         = done_q;
    assign degamma_en_active = en_q;
    assign bank_sel          = bank_q;
    assign lut_we            = we_q;
    assign lut_wbank         = ~bank_q;
    assign lut_waddr         = waddr_q;
    assign lut_wdata         = cp_q ? lut_rdata : wdata_q;
    assign lut_rd_en         = rd_q;
    assign lut_rbank         = bank_q;
    assign lut_raddr         = cnt_q[IN_DW-1:0];

endmodule

// File: tb/tb_degamma_lut_ctrl.sv
// Self-checking bench for degamma_lut_ctrl with a two-bank LUT RAM stand-in
// and an array-level model of bank contents, bank select and enable.
module tb_degamma_lut_ctrl;
    import degamma_pkg::*;

    localparam int AW = DG_IN_DW;
    localparam int DW = DG_OUT_DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          vsync_in = 1'b0;
    logic          reg_degamma_en = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_ready, commit_pending, swap_done, degamma_en_active;
    logic          bank_sel, lut_we, lut_wbank, lut_rd_en, lut_rbank;
    logic [AW-1:0] lut_waddr, lut_raddr;
    logic [DW-1:0] lut_wdata, lut_rdata;

    always #5 clk = ~clk;

    degamma_lut_ctrl dut (
        .clk(clk), .rstn(rstn), .vsync_in(vsync_in),
        .reg_degamma_en(reg_degamma_en), .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_ready(cfg_ready),
        .commit_pending(commit_pending), .swap_done(swap_done),
        .degamma_en_active(degamma_en_active), .bank_sel(bank_sel),
        .lut_we(lut_we), .lut_wbank(lut_wbank), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .lut_rd_en(lut_rd_en),
        .lut_rbank(lut_rbank), .lut_raddr(lut_raddr),
        .lut_rdata(lut_rdata)
    );

    entry_t ram [2][LUT_DEPTH];
    entry_t mdl [2][LUT_DEPTH];
    entry_t rdata_q;
    bit     ram_clr = 1'b1;
    bit     m_sel, m_en, m_pend;
    int     n_chk = 0;
    int     n_fail = 0;

    assign lut_rdata = rdata_q;

    function automatic entry_t init_val(int b, int i);
        return entry_t'((b * 1237 + i * 29 + 5) % 4096);
    endfunction

    // Two-bank LUT RAM with 1-cycle read latency
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < LUT_DEPTH; i++)
                    ram[b][i] <= init_val(b, i);
            rdata_q <= '0;
        end else begin
            if (lut_we) ram[lut_wbank][lut_waddr] <= lut_wdata;
            if (lut_rd_en) rdata_q <= ram[lut_rbank][lut_raddr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp_banks(input string nm);
        int bad = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LUT_DEPTH; i++)
                if (ram[b][i] !== mdl[b][i]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic hw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = !m_pend;
        cfg_wr = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        step();
        cfg_wr = 1'b0;
        chk("hw_we", lut_we, acc);
        if (acc) begin
            chk("hw_waddr", lut_waddr, a);
            chk("hw_wdata", lut_wdata, d);
            chk("hw_wbank", lut_wbank, !m_sel);
            mdl[!m_sel][a] = d;
        end
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        m_pend = 1'b1;
        chk("commit_pending", commit_pending, 1);
        chk("commit_ready", cfg_ready, 0);
    endtask

    task automatic vs_rise(output bit sw);
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        m_en = reg_degamma_en;
        sw = m_pend;
        if (m_pend) begin
            m_sel = !m_sel;
            m_pend = 1'b0;
        end
        chk("vs_bank_sel", bank_sel, m_sel);
        chk("vs_en_active", degamma_en_active, m_en);
        chk("vs_pending", commit_pending, 0);
        chk("vs_ready", cfg_ready, !sw);
    endtask

    task automatic run_copy(input bit poke);
        int cyc = 0;
        int wes = 0;
        int rds = 0;
        chk("copy_rbank", lut_rbank, m_sel);
        chk("copy_wbank", lut_wbank, !m_sel);
        while (!swap_done && cyc < 400) begin
            if (lut_we) wes++;
            if (lut_rd_en) rds++;
            if (poke) begin
                cfg_wr = 1'b1;
                cfg_addr = 8'h20;
                cfg_wdata = 12'hABC;
            end
            step();
            cyc++;
        end
        cfg_wr = 1'b0;
        chk("copy_cycles", cyc, LUT_DEPTH + 1);
        chk("copy_writes", wes, LUT_DEPTH);
        chk("copy_reads", rds, LUT_DEPTH);
        chk("done_ready", cfg_ready, 1);
        for (int i = 0; i < LUT_DEPTH; i++) mdl[!m_sel][i] = mdl[m_sel][i];
        step();
        chk("done_pulse_end", swap_done, 0);
        cmp_banks("bank_contents");
    endtask

    typedef struct {
        bit            wr;
        bit            cm;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            e_we;
        bit            e_rdy;
        bit            e_pend;
    } vec_t;

    vec_t tbl [7];

    initial begin
        bit sw;
        int k;
        tbl[0] = '{1, 0, 8'h10, 12'h123, 1, 1, 0};
        tbl[1] = '{1, 0, 8'hFF, 12'hFFF, 1, 1, 0};
        tbl[2] = '{1, 0, 8'h00, 12'h001, 1, 1, 0};
        tbl[3] = '{0, 0, 8'h00, 12'h000, 0, 1, 0};
        tbl[4] = '{0, 1, 8'h00, 12'h000, 0, 0, 1};
        tbl[5] = '{1, 0, 8'h30, 12'h555, 0, 0, 1};
        tbl[6] = '{0, 1, 8'h00, 12'h000, 0, 0, 1};
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LUT_DEPTH; i++) mdl[b][i] = init_val(b, i);
        m_sel = 0;
        m_en = 0;
        m_pend = 0;

        step(3);
        ram_clr = 1'b0;
        rstn = 1'b1;
        step();
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_en_active", degamma_en_active, 0);
        chk("rst_lut_we", lut_we, 0);
        chk("rst_pending", commit_pending, 0);
        chk("rst_rd_en", lut_rd_en, 0);
        chk("rst_swap_done", swap_done, 0);

        for (int i = 0; i < 7; i++) begin
            cfg_wr = tbl[i].wr;
            cfg_commit = tbl[i].cm;
            cfg_addr = tbl[i].a;
            cfg_wdata = tbl[i].d;
            step();
            cfg_wr = 1'b0;
            cfg_commit = 1'b0;
            chk("tbl_we", lut_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk("tbl_waddr", lut_waddr, tbl[i].a);
                chk("tbl_wdata", lut_wdata, tbl[i].d);
                chk("tbl_wbank", lut_wbank, 1);
                mdl[1][tbl[i].a] = tbl[i].d;
            end
            chk("tbl_ready", cfg_ready, tbl[i].e_rdy);
            chk("tbl_pending", commit_pending, tbl[i].e_pend);
        end
        m_pend = tbl[6].e_pend;
        vs_rise(sw);
        run_copy(0);
        chk("copied_0x10", ram[0][8'h10], 12'h123);

        // Commit coincident with vsync rise waits for the next rise
        vsync_in = 1'b0;
        step();
        cfg_commit = 1'b1;
        vsync_in = 1'b1;
        step();
        cfg_commit = 1'b0;
        vsync_in = 1'b0;
        chk("coinc_no_swap", bank_sel, m_sel);
        chk("coinc_pending", commit_pending, 1);
        m_pend = 1'b1;
        step(3);
        vs_rise(sw);
        run_copy(0);

        reg_degamma_en = 1'b1;
        vs_rise(sw);
        reg_degamma_en = 1'b0;
        step(5);
        chk("en_midframe_hold", degamma_en_active, 1);
        vs_rise(sw);

        hw(8'h20, 12'h7A5);
        commit();
        vs_rise(sw);
        run_copy(1);
        chk("copy_0x20_kept", ram[!m_sel][8'h20], 12'h7A5);

        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 12);
            for (int j = 0; j < nw; j++) begin
                hw(AW'($urandom), DW'($urandom));
                if ($urandom_range(0, 1) == 1) step($urandom_range(0, 3));
            end
            reg_degamma_en = 1'($urandom);
            step();
            if ($urandom_range(0, 3) != 0) begin
                commit();
                hw(AW'($urandom), DW'($urandom));
            end
            vs_rise(sw);
            if (sw) run_copy(1'($urandom));
            else cmp_banks("bank_contents_noswap");
        end

        hw(8'h05, 12'h0F0);
        commit();
        vs_rise(sw);
        k = 0;
        while (!(lut_rd_en && lut_raddr == 8'd100) && k < 300) begin
            step();
            k++;
        end
        chk("reach_addr_100", k < 300, 1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_we", lut_we, 0);
        chk("rst_mid_rd_en", lut_rd_en, 0);
        chk("rst_mid_bank_sel", bank_sel, 0);
        chk("rst_mid_en", degamma_en_active, 0);
        step(2);
        rstn = 1'b1;
        step();
        chk("rel_ready", cfg_ready, 1);
        chk("rel_pending", commit_pending, 0);
        chk("rel_we", lut_we, 0);
        chk("rel_bank_sel", bank_sel, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
